bus_xfer_ctrl: RTL and testbench

// - Sequences register-to-register moves over the shared 16-bit tri-state bus of the microcontroller.
// - Drives the per-register load enables (RegN_En) and the tri-state output enables (RegN_out_Tri_EN).
// - Arbitrates between two requesters, round-robin: req0 = control unit, req1 = debug/load port.
// - Guarantees at most one bus driver per cycle, plus a dead cycle between transfers (break-before-make).

---
 rtl/bus_ctrl_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/bus_xfer_ctrl.sv | 122 ++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared types, defaults and index decode for the bus transfer controller
package bus_ctrl_pkg;

    localparam int DEF_N_REGS = 8;
    localparam int DEF_IDX_W  = 3;

    // Decode width is fixed so one function serves every register count;
    // bits at or above N_REGS flag an out-of-range index.
    localparam int MAX_IDX_W = 5;
    localparam int MAX_REGS  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_LATCH   = 2'd2,
        ST_RELEASE = 2'd3
    } xfer_state_t;

    function automatic logic [MAX_REGS-1:0] idx_onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a one-bit priority pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    logic rr_ptr;

    // Contention goes to the pointer; a lone requester always wins.
    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_idx = rr_ptr;
        end else begin
            gnt_idx = req[1];
        end
    end

    // Priority flips to the other requester after every grant, rejected ones included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
        end else if (advance) begin
            rr_ptr <= ~gnt_idx;
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - sequences break-before-make register moves over the shared tri-state bus
module bus_xfer_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int N_REGS     = DEF_N_REGS,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [IDX_W-1:0]  req0_src,
    input  logic [IDX_W-1:0]  req0_dst,
    input  logic [IDX_W-1:0]  req1_src,
    input  logic [IDX_W-1:0]  req1_dst,
    output logic [1:0]        req_ready,
    output logic [N_REGS-1:0] tri_en,
    output logic [N_REGS-1:0] reg_en,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic              err
);

    xfer_state_t         state;
    logic [1:0]          settle_cnt;
    logic [N_REGS-1:0]   dst_oh_q;
    logic                owner_q;

    logic                gnt_idx;
    logic                gnt_valid;
    logic                grant_take;
    logic [IDX_W-1:0]    sel_src;
    logic [IDX_W-1:0]    sel_dst;
    logic [MAX_REGS-1:0] src_full;
    logic [MAX_REGS-1:0] dst_full;
    logic                reject;

    assign grant_take = (state == ST_IDLE) && gnt_valid;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (grant_take),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Select the granted move and decode it; high decode bits mark an out-of-range index.
    always_comb begin
        sel_src  = gnt_idx ? req1_src : req0_src;
        sel_dst  = gnt_idx ? req1_dst : req0_dst;
        src_full = idx_onehot(MAX_IDX_W'(sel_src));
        dst_full = idx_onehot(MAX_IDX_W'(sel_dst));
        reject   = (sel_src == sel_dst)
                 || (|src_full[MAX_REGS-1:N_REGS])
                 || (|dst_full[MAX_REGS-1:N_REGS]);
    end

    // Transfer FSM: every output is a register so nothing on the bus follows inputs combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            dst_oh_q   <= '0;
            owner_q    <= 1'b0;
            req_ready  <= '0;
            tri_en     <= '0;
            reg_en     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
            err        <= 1'b0;
        end else begin
            req_ready <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        req_ready <= gnt_idx ? 2'b10 : 2'b01;
                        owner_q   <= gnt_idx;
                        if (reject) begin
                            err     <= 1'b1;
                            done_id <= gnt_idx;
                        end else begin
                            tri_en     <= src_full[N_REGS-1:0];
                            dst_oh_q   <= dst_full[N_REGS-1:0];
                            settle_cnt <= '0;
                            busy       <= 1'b1;
                            state      <= ST_DRIVE;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (int'(settle_cnt) >= SETTLE_CYC - 1) begin
                        reg_en <= dst_oh_q;
                        state  <= ST_LATCH;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                ST_LATCH: begin
                    tri_en <= '0;
                    reg_en <= '0;
                    state  <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    done_id <= owner_q;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - scoreboard bench for bus_xfer_ctrl with a 16-bit register bus model
module tb_bus_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [2:0] req0_src, req0_dst, req1_src, req1_dst;
    logic [1:0] req_ready;
    logic [7:0] tri_en, reg_en;
    logic       busy, done, done_id, err;

    logic [1:0] v6;
    logic [2:0] s6, d6;
    logic [1:0] rdy6;
    logic [5:0] tri6, reg6;
    logic       busy6, done6, id6, err6;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        id;
        logic        is_err;
        logic [2:0]  dst;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_regs[8];
    logic [15:0] bus_regs[8];
    logic [15:0] bus;
    logic        init_model;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.N_REGS(8), .IDX_W(3), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req0_src(req0_src), .req0_dst(req0_dst), .req1_src(req1_src), .req1_dst(req1_dst),
        .req_ready(req_ready), .tri_en(tri_en), .reg_en(reg_en),
        .busy(busy), .done(done), .done_id(done_id), .err(err)
    );

    bus_xfer_ctrl #(.N_REGS(6), .IDX_W(3), .SETTLE_CYC(1)) dut6 (
        .clk(clk), .rst(rst), .req_valid(v6),
        .req0_src(s6), .req0_dst(d6), .req1_src(3'd0), .req1_dst(3'd1),
        .req_ready(rdy6), .tri_en(tri6), .reg_en(reg6),
        .busy(busy6), .done(done6), .done_id(id6), .err(err6)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input int k);
        return 16'(32'hA5C3 ^ (k * 32'h1357));
    endfunction

    // Bus model: whichever register has tri_en drives the bus; reg_en loads it.
    always_comb begin
        bus = '0;
        for (int k = 0; k < 8; k++) if (tri_en[k]) bus = bus_regs[k];
    end

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (init_model) bus_regs[k] <= init_val(k);
            else if (reg_en[k]) bus_regs[k] <= bus;
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on each done or err pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check_eq("onehot_inv", {$onehot0(tri_en), $onehot0(reg_en), (reg_en == 8'h0) || (tri_en != 8'h0)}, 3'b111);
            check_eq("idle_no_tri", busy || (tri_en == 8'h0), 1);
            if (done || err) begin
                check_eq("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("kind_err", err, e.is_err);
                    check_eq("done_id", done_id, e.id);
                    if (done && !e.is_err) check_eq("dst_data", bus_regs[e.dst], e.data);
                end
            end
        end
    end

    task automatic expect_move(input logic id, input logic [2:0] s, input logic [2:0] d);
        exp_t e;
        e.id  = id;
        e.dst = d;
        if (s == d) begin
            e.is_err = 1'b1;
            e.data   = '0;
        end else begin
            e.is_err    = 1'b0;
            e.data      = ref_regs[s];
            ref_regs[d] = ref_regs[s];
        end
        sb.push_back(e);
    endtask

    task automatic issue(input logic id, input logic [2:0] s, input logic [2:0] d);
        int n;
        expect_move(id, s, d);
        if (id) begin req1_src = s; req1_dst = d; end
        else    begin req0_src = s; req0_dst = d; end
        req_valid[id] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[id] && n < 40);
        check_eq("ready_seen", req_ready[id], 1);
        req_valid[id] = 1'b0;
    endtask

    task automatic issue_both(input logic [2:0] s0, input logic [2:0] d0, input logic [2:0] s1, input logic [2:0] d1);
        int n;
        bit first;
        expect_move(0, s0, d0);
        expect_move(1, s1, d1);
        req0_src = s0; req0_dst = d0; req1_src = s1; req1_dst = d1;
        req_valid = 2'b11;
        first = 1'b1;
        n = 0;
        while (req_valid != 2'b00 && n < 60) begin
            @(negedge clk); n++;
            if (req_ready != 2'b00) begin
                if (first) begin
                    check_eq("rr_first", req_ready, 2'b01);
                    first = 1'b0;
                end
                req_valid = req_valid & ~req_ready;
            end
        end
        check_eq("rr_drain", req_valid, 2'b00);
    endtask

    initial begin
        logic [7:0] exp_tri[4];
        logic [7:0] exp_reg[4];
        logic [1:0] exp_rdy[4];
        logic [1:0] exp_bd[4];
        logic       rid;
        logic [2:0] rs, rd;
        int         n;

        rst = 1'b0; req_valid = '0; init_model = 1'b1;
        req0_src = '0; req0_dst = '0; req1_src = '0; req1_dst = '0;
        v6 = '0; s6 = '0; d6 = '0;
        for (int k = 0; k < 8; k++) ref_regs[k] = init_val(k);

        #90;
        init_model = 1'b0;
        check_eq("rst_outs", {req_ready, tri_en, reg_en, busy, done, done_id, err}, 0);
        #10 rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_outs", {req_ready, tri_en, reg_en, busy, done, done_id, err}, 0);

        // Single move 1 -> 0: cycle-by-cycle enables, ready, busy and done.
        exp_tri = '{8'h02, 8'h02, 8'h00, 8'h00};
        exp_reg = '{8'h00, 8'h01, 8'h00, 8'h00};
        exp_rdy = '{2'b01, 2'b00, 2'b00, 2'b00};
        exp_bd  = '{2'b10, 2'b10, 2'b10, 2'b01};
        expect_move(0, 3'd1, 3'd0);
        req0_src = 3'd1; req0_dst = 3'd0; req_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = 2'b00;
            check_eq($sformatf("edge%0d_tri", c), tri_en, exp_tri[c]);
            check_eq($sformatf("edge%0d_reg", c), reg_en, exp_reg[c]);
            check_eq($sformatf("edge%0d_rdy", c), req_ready, exp_rdy[c]);
            check_eq($sformatf("edge%0d_busy_done", c), {busy, done}, exp_bd[c]);
        end

        // Rejected move from requester 1 (src == dst); also moves the pointer back to 0.
        issue(1, 3'd3, 3'd3);
        repeat (3) begin
            @(negedge clk);
            check_eq("rej_quiet", {busy, tri_en, reg_en}, 0);
        end

        // Contention with pointer at 0: req0 first, twice in a row.
        issue_both(3'd2, 3'd3, 3'd4, 3'd5);
        issue_both(3'd2, 3'd3, 3'd4, 3'd5);

        // Reset asserted during LATCH drops enables at once and loses the move.
        req0_src = 3'd2; req0_dst = 3'd4; req_valid = 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 40);
        req_valid = 2'b00;
        n = 0;
        while (reg_en == 8'h00 && n < 10) begin @(negedge clk); n++; end
        check_eq("latch_seen", reg_en, 8'h10);
        #2 rst = 1'b0;
        #1 check_eq("rst_async", {tri_en, reg_en, busy}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("no_done_after_rst", {done, busy}, 0);
        end

        // Six-register instance: index 7 is out of range and must be rejected.
        s6 = 3'd7; d6 = 3'd0; v6 = 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy6[0] && n < 40);
        v6 = 2'b00;
        check_eq("n6_err", {rdy6, err6, id6}, 4'b0110);
        repeat (3) begin
            @(negedge clk);
            check_eq("n6_quiet", {tri6, reg6, busy6, done6}, 0);
        end

        // Random stream of moves checked against the bus model.
        for (int i = 0; i < 200; i++) begin
            rid = 1'($urandom_range(0, 1));
            rs  = 3'($urandom_range(0, 7));
            rd  = rs + 3'($urandom_range(1, 7));
            issue(rid, rs, rd);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        check_eq("sb_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
